// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width defaults, load-type encodings
// and the MEM->WB stage occupancy states.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W     = 32;
  localparam int unsigned CPU_REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    LOAD_LW  = 3'b000,
    LOAD_LB  = 3'b001,
    LOAD_LBU = 3'b010,
    LOAD_LH  = 3'b011,
    LOAD_LHU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_MAIN  = 2'b01,
    OCC_FULL  = 2'b10
  } occ_e;

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the addressed byte/half from
// the raw memory word and sign- or zero-extends it.
module load_extend
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (addr_lo)
      2'b00:   byte_sel = data[7:0];
      2'b01:   byte_sel = data[15:8];
      2'b10:   byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    // Half select ignores addr_lo[0]: misaligned halves are not trapped.
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    ext = data;
    case (load_type)
      LOAD_LB:  ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: ext = {{(DATA_W-8){1'b0}}, byte_sel};
      LOAD_LH:  ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LOAD_LHU: ext = {{(DATA_W-16){1'b0}}, half_sel};
      default:  ext = data;
    endcase
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush, load
// extension, write-back mux and a forwarding tap for the hazard unit.
module mem_wb_skid_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = CPU_DATA_W,
  parameter int unsigned REG_ADDR_W = CPU_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_reg_dest,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [2:0]            in_load_type,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_wb_data,
  output logic [REG_ADDR_W-1:0] out_reg_dest,
  output logic                  out_reg_write,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg_dest,
  output logic [DATA_W-1:0]     fwd_data
);

  typedef struct packed {
    logic [DATA_W-1:0]     mem_data;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] reg_dest;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [2:0]            load_type;
  } payload_t;

  occ_e     state, state_next;
  logic     in_ready_q;
  payload_t main_q, skid_q, in_payload;
  logic     main_valid, skid_valid;
  logic     accept, pop;
  logic     load_main_in, load_main_skid, load_skid;
  logic [DATA_W-1:0] load_word;

  assign in_payload = '{mem_data:   in_mem_data,
                        alu_result: in_alu_result,
                        reg_dest:   in_reg_dest,
                        reg_write:  in_reg_write,
                        mem_to_reg: in_mem_to_reg,
                        load_type:  in_load_type};

  assign accept = in_valid & in_ready_q;
  assign pop    = main_valid & out_ready;

  // in_ready is a flop fed from next-state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != OCC_FULL);
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: if (accept) state_next = OCC_MAIN;
        OCC_MAIN: begin
          if (pop && !accept)      state_next = OCC_EMPTY;
          else if (!pop && accept) state_next = OCC_FULL;
        end
        OCC_FULL:  if (pop) state_next = OCC_MAIN;
        default:   state_next = OCC_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_valid     = (state != OCC_EMPTY);
    skid_valid     = (state == OCC_FULL);
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush) begin
      load_main_in   = accept & ((state == OCC_EMPTY) | ((state == OCC_MAIN) & pop));
      load_main_skid = (state == OCC_FULL) & pop;
      load_skid      = accept & (state == OCC_MAIN) & ~pop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_payload;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_payload;
    end
  end

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .data      (main_q.mem_data),
    .addr_lo   (main_q.alu_result[1:0]),
    .load_type (main_q.load_type),
    .ext       (load_word)
  );

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid;
  assign out_wb_data   = main_q.mem_to_reg ? load_word : main_q.alu_result;
  assign out_reg_dest  = main_q.reg_dest;
  assign out_reg_write = main_valid & main_q.reg_write & (main_q.reg_dest != '0);
  assign fwd_valid     = out_reg_write;
  assign fwd_reg_dest  = out_reg_dest;
  assign fwd_data      = out_wb_data;

  // skid_valid is kept for readability of the occupancy decode.
  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage: vector table for extension and
// write-back mux, hand sequences for back-pressure, flush and reset.
module tb_mem_wb_skid_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_mem_data, in_alu_result;
  logic [4:0]  in_reg_dest;
  logic        in_reg_write, in_mem_to_reg;
  logic [2:0]  in_load_type;
  logic        out_valid, out_ready, out_reg_write, fwd_valid;
  logic [31:0] out_wb_data, fwd_data;
  logic [4:0]  out_reg_dest, fwd_reg_dest;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
    .in_reg_dest(in_reg_dest), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_load_type(in_load_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_data(out_wb_data), .out_reg_dest(out_reg_dest),
    .out_reg_write(out_reg_write),
    .fwd_valid(fwd_valid), .fwd_reg_dest(fwd_reg_dest), .fwd_data(fwd_data)
  );

  typedef struct {
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [31:0] exp_wb;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] dest, input logic rw, input logic m2r, input logic [2:0] lt);
    in_valid      = v;
    in_mem_data   = mem;
    in_alu_result = alu;
    in_reg_dest   = dest;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
    in_load_type  = lt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    localparam logic [31:0] D = 32'h8081_F2F3;
    localparam logic [31:0] E = 32'h1234_5678;
    vecs[0]  = '{32'h0, 32'h10,   5'd3,  1'b1, 1'b0, 3'd0, 32'h0000_0010, 1'b1};
    vecs[1]  = '{D,     32'h1001, 5'd4,  1'b1, 1'b1, 3'd1, 32'hFFFF_FFF2, 1'b1};
    vecs[2]  = '{D,     32'h1003, 5'd5,  1'b1, 1'b1, 3'd2, 32'h0000_0080, 1'b1};
    vecs[3]  = '{D,     32'h1002, 5'd6,  1'b1, 1'b1, 3'd3, 32'hFFFF_8081, 1'b1};
    vecs[4]  = '{D,     32'h1000, 5'd7,  1'b1, 1'b1, 3'd4, 32'h0000_F2F3, 1'b1};
    vecs[5]  = '{D,     32'h1003, 5'd8,  1'b1, 1'b1, 3'd3, 32'hFFFF_8081, 1'b1};
    vecs[6]  = '{D,     32'h1002, 5'd9,  1'b1, 1'b1, 3'd0, D,             1'b1};
    vecs[7]  = '{D,     32'h1000, 5'd10, 1'b1, 1'b1, 3'd7, D,             1'b1};
    vecs[8]  = '{E,     32'h2000, 5'd11, 1'b1, 1'b1, 3'd1, 32'h0000_0078, 1'b1};
    vecs[9]  = '{E,     32'h2002, 5'd12, 1'b1, 1'b1, 3'd3, 32'h0000_1234, 1'b1};
    vecs[10] = '{D,     32'h44,   5'd0,  1'b1, 1'b0, 3'd0, 32'h0000_0044, 1'b0};
    vecs[11] = '{D,     32'h1000, 5'd13, 1'b0, 1'b1, 3'd2, 32'h0000_00F3, 1'b0};
    vecs[12] = '{E,     32'h2003, 5'd14, 1'b1, 1'b1, 3'd5, E,             1'b1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);

    // Reset state
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wb_data", out_wb_data, 0);
    chk("rst_reg_dest", out_reg_dest, 0);
    chk("rst_reg_write", out_reg_write, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // Vector table, streamed back to back
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].mem, vecs[i].alu, vecs[i].dest, vecs[i].rw, vecs[i].m2r, vecs[i].lt);
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_wb", i), out_wb_data, vecs[i].exp_wb);
      chk($sformatf("vec%0d_dest", i), out_reg_dest, vecs[i].dest);
      chk($sformatf("vec%0d_rw", i), out_reg_write, vecs[i].exp_rw);
      chk($sformatf("vec%0d_fwd_valid", i), fwd_valid, vecs[i].exp_rw);
      chk($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].exp_wb);
      chk($sformatf("vec%0d_fwd_dest", i), fwd_reg_dest, vecs[i].dest);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_rw", out_reg_write, 0);
    chk("drain_hold_wb", out_wb_data, 32'h1234_5678);

    // Back-pressure: A then B with out_ready low
    out_ready = 1'b0;
    drive(1'b1, '0, 32'hA, 5'd1, 1'b1, 1'b0, '0);
    step();
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_data", out_wb_data, 32'hA);
    chk("bp_a_in_ready", in_ready, 1);
    drive(1'b1, '0, 32'hB, 5'd2, 1'b1, 1'b0, '0);
    step();
    chk("bp_b_in_ready", in_ready, 0);
    chk("bp_b_hold_a", out_wb_data, 32'hA);
    drive(1'b1, '0, 32'hC, 5'd3, 1'b1, 1'b0, '0);
    step();
    chk("bp_c_in_ready", in_ready, 0);
    chk("bp_c_hold_a", out_wb_data, 32'hA);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    out_ready = 1'b1;
    step();
    chk("bp_pop_b_valid", out_valid, 1);
    chk("bp_pop_b_data", out_wb_data, 32'hB);
    chk("bp_pop_b_in_ready", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // Streaming IDs 1..10
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, '0, 32'(i), 5'd7, 1'b1, 1'b0, '0);
      step();
      chk($sformatf("stream%0d_data", i), out_wb_data, 32'(i));
      chk($sformatf("stream%0d_valid", i), out_valid, 1);
      chk($sformatf("stream%0d_in_ready", i), in_ready, 1);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    step();
    chk("stream_empty", out_valid, 0);

    // Flush with both registers full and a new input offered
    out_ready = 1'b0;
    drive(1'b1, '0, 32'h51, 5'd4, 1'b1, 1'b0, '0);
    step();
    drive(1'b1, '0, 32'h52, 5'd5, 1'b1, 1'b0, '0);
    step();
    chk("fl_full_in_ready", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, '0, 32'h53, 5'd6, 1'b1, 1'b0, '0);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_fwd_valid", fwd_valid, 0);
    chk("fl_rw", out_reg_write, 0);
    out_ready = 1'b1;
    step();
    chk("fl_not_captured", out_valid, 0);

    // dest 0 with reg_write set
    drive(1'b1, '0, 32'h77, 5'd0, 1'b1, 1'b0, '0);
    step();
    chk("r0_valid", out_valid, 1);
    chk("r0_rw", out_reg_write, 0);
    chk("r0_fwd_valid", fwd_valid, 0);

    // Reset mid-stream
    drive(1'b1, '0, 32'h99, 5'd9, 1'b1, 1'b0, '0);
    step();
    chk("pre_rst_data", out_wb_data, 32'h99);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_wb", out_wb_data, 0);
    chk("mid_rst_dest", out_reg_dest, 0);
    chk("mid_rst_rw", out_reg_write, 0);
    chk("mid_rst_fwd_valid", fwd_valid, 0);
    chk("mid_rst_fwd_data", fwd_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    step();
    chk("post_mid_rst_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
